dial_poller: RTL and testbench

DIAL_POLLER -- requirements
Module: dial_poller

---
 rtl/dial_poller.sv | 168 ++++++++++++++++
 tb/tb_dial_poller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dial_poller.sv
// dial_poller
// -----------
// Periodically reads a dial position from an Avalon-MM PIO slave. The slave
// has a fixed read latency of 1 and no waitrequest. The block then reports
// the captured value and the signed change since the previous capture.
//
// Poll cycle, with enable held high:
//   WAIT (POLL_PERIOD cycles) -> READ -> CAPTURE -> COMPARE -> WAIT ...
// This gives exactly one read strobe every POLL_PERIOD+3 cycles.
//
// Parameters
//   POLL_PERIOD  cycles spent in WAIT between reads (4 .. 2^24-1)
//   DEADBAND     smallest |delta| that counts as a change (0 .. 127)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   enable        polling permitted while high
//   avm_address   PIO address, always 0
//   avm_read      one-cycle read strobe (state READ)
//   avm_readdata  PIO read data; only bits [7:0] are used
//   dial_value    last captured dial value
//   value_valid   set once the first capture has completed
//   delta         new minus previous dial value, signed, modulo 256
//   changed       one-cycle pulse when |delta| > DEADBAND
//   busy          high whenever the FSM is not in IDLE
module dial_poller #(
    parameter int unsigned POLL_PERIOD = 50000,
    parameter int unsigned DEADBAND    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic [7:0]  dial_value,
    output logic        value_valid,
    output logic [7:0]  delta,
    output logic        changed,
    output logic        busy
);

    localparam logic [23:0] RELOAD      = 24'(POLL_PERIOD - 1);
    localparam logic [7:0]  DEADBAND_L  = 8'(DEADBAND);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_CAPTURE,
        ST_COMPARE
    } state_t;

    state_t      state_q,   state_d;
    logic [23:0] count_q,   count_d;
    logic [7:0]  hold_q,    hold_d;
    logic [7:0]  dial_q,    dial_d;
    logic [7:0]  delta_q,   delta_d;
    logic        valid_q,   valid_d;
    logic        changed_q, changed_d;

    logic [7:0]  diff;
    logic [7:0]  abs_diff;

    // The upper 24 bits of the PIO word carry nothing for the dial.
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^avm_readdata[31:8];

    // The modulo-256 subtraction already gives the signed wrap-around result.
    // The magnitude of 0x80 comes out as 0x80, which is 128 read unsigned.
    assign diff     = hold_q - dial_q;
    assign abs_diff = diff[7] ? (~diff + 8'd1) : diff;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            hold_q    <= '0;
            dial_q    <= '0;
            delta_q   <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            dial_q    <= dial_d;
            delta_q   <= delta_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hold_d    = hold_q;
        dial_d    = dial_q;
        delta_d   = delta_q;
        valid_d   = valid_q;
        changed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                    count_d = RELOAD;
                end
            end

            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q == 24'd0) begin
                    state_d = ST_READ;
                end else begin
                    count_d = count_q - 24'd1;
                end
            end

            // The read itself is not abortable. A drop of enable is only
            // acted on once COMPARE has run.
            ST_READ: begin
                state_d = ST_CAPTURE;
            end

            // With read latency 1, the data for the READ strobe is on the bus now.
            ST_CAPTURE: begin
                hold_d  = avm_readdata[7:0];
                state_d = ST_COMPARE;
            end

            ST_COMPARE: begin
                dial_d  = hold_q;
                valid_d = 1'b1;
                if (valid_q) begin
                    delta_d   = diff;
                    changed_d = (abs_diff > DEADBAND_L);
                end else begin
                    // There is no previous value to compare against yet.
                    delta_d   = 8'h00;
                end
                if (enable) begin
                    state_d = ST_WAIT;
                    count_d = RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign avm_read    = (state_q == ST_READ);
    assign avm_address = 2'b00;
    assign busy        = (state_q != ST_IDLE);
    assign dial_value  = dial_q;
    assign value_valid = valid_q;
    assign delta       = delta_q;
    assign changed     = changed_q;

endmodule

// File: tb/tb_dial_poller.sv
// Directed bench for dial_poller.
// Two instances share one stimulus: DEADBAND=0 (suffix _a) and DEADBAND=2
// (suffix _b). POLL_PERIOD=4, so reads are 7 cycles apart.
// The PIO slave model returns the dial word only in the cycle after a read
// strobe, and a filler word at all other times.
module tb_dial_poller;

    localparam int unsigned PERIOD = 4;
    localparam logic [31:0] FILLER = 32'hFFFF_FF5A;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] rdata = FILLER;
    logic [31:0] src = 32'h0;

    logic [1:0]  addr_a, addr_b;
    logic        rd_a, rd_b;
    logic [7:0]  dial_a, dial_b, dlt_a, dlt_b;
    logic        valid_a, valid_b, chg_a, chg_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdata <= rd_a ? src : FILLER;

    dial_poller #(.POLL_PERIOD(PERIOD), .DEADBAND(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(addr_a), .avm_read(rd_a), .avm_readdata(rdata),
        .dial_value(dial_a), .value_valid(valid_a), .delta(dlt_a),
        .changed(chg_a), .busy(busy_a)
    );

    dial_poller #(.POLL_PERIOD(PERIOD), .DEADBAND(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(addr_b), .avm_read(rd_b), .avm_readdata(rdata),
        .dial_value(dial_b), .value_valid(valid_b), .delta(dlt_b),
        .changed(chg_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The address must be 0 in every cycle, and the two instances must strobe together.
    always @(negedge clk) begin
        chk("address_zero", {28'd0, addr_a, addr_b}, 32'd0);
        chk("read_lockstep", {31'd0, rd_b}, {31'd0, rd_a});
    end

    // Called at a negedge. Returns at the negedge where avm_read is high,
    // or after the budget runs out.
    task automatic wait_read(input int budget);
        int n = 0;
        while (rd_a !== 1'b1 && n < budget) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("read_issued", {31'd0, rd_a}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dial"},  {16'd0, dial_a, dial_b}, 32'd0);
        chk({tag, "_delta"}, {16'd0, dlt_a, dlt_b}, 32'd0);
        chk({tag, "_flags"}, {24'd0, valid_a, valid_b, chg_a, chg_b,
                              rd_a, rd_b, busy_a, busy_b}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  dial;
        logic [7:0]  dlt;
        logic        ca;
        logic        cb;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int  prev_cyc;
        bit  seen;

        vecs[0]  = '{32'h0000_0005, 8'h05, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0005, 8'h05, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_00FF, 8'hFF, 8'hFA, 1'b1, 1'b1};
        vecs[3]  = '{32'h0000_0000, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[4]  = '{32'h0000_00FF, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0000, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000_0080, 8'h80, 8'h80, 1'b1, 1'b1};
        vecs[7]  = '{32'h0000_0010, 8'h10, 8'h90, 1'b1, 1'b1};
        vecs[8]  = '{32'h0000_0012, 8'h12, 8'h02, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_0015, 8'h15, 8'h03, 1'b1, 1'b1};
        vecs[10] = '{32'h0000_0015, 8'h15, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{32'hABCD_0033, 8'h33, 8'h1E, 1'b1, 1'b1};
        vecs[12] = '{32'h0000_0134, 8'h34, 8'h01, 1'b1, 1'b0};

        // Reset state, held with enable high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        $display("txn reset: outputs checked while reset_n=0");

        // Release reset. With P=4, the read appears after edge E0+4.
        src = vecs[0].rd;
        reset_n = 1'b1;
        @(posedge clk);                 // E0
        repeat (3) @(posedge clk);      // E1..E3
        @(negedge clk);
        chk("first_read_early", {30'd0, rd_a, busy_a}, 32'd1);
        @(posedge clk);                 // E4
        @(negedge clk);
        chk("first_read_latency", {31'd0, rd_a}, 32'd1);

        // Table of polls.
        prev_cyc = 0;
        for (int i = 0; i < 13; i++) begin
            src = vecs[i].rd;
            wait_read(20);
            if (i > 0) chk("read_interval", cyc - prev_cyc, 32'd7);
            prev_cyc = cyc;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("vec_dial",  {16'd0, dial_a, dial_b}, {16'd0, vecs[i].dial, vecs[i].dial});
            chk("vec_delta", {16'd0, dlt_a, dlt_b},   {16'd0, vecs[i].dlt, vecs[i].dlt});
            chk("vec_valid", {30'd0, valid_a, valid_b}, 32'd3);
            chk("vec_changed", {30'd0, chg_a, chg_b}, {30'd0, vecs[i].ca, vecs[i].cb});
            $display("txn %0d: rd=%h dial=%h delta=%h chg=%b%b", i, vecs[i].rd,
                     dial_a, dlt_a, chg_a, chg_b);
            @(posedge clk);
            @(negedge clk);
            chk("pulse_one_cycle", {30'd0, chg_a, chg_b}, 32'd0);
            chk("delta_held", {16'd0, dlt_a, dlt_b}, {16'd0, vecs[i].dlt, vecs[i].dlt});
        end

        // Drop enable in the READ cycle. The transaction still completes, then the FSM idles.
        src = 32'h0000_0040;
        wait_read(20);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drop_busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("drop_dial", {16'd0, dial_a, dlt_a}, {16'd0, 8'h40, 8'h0C});
        chk("drop_changed", {30'd0, chg_a, chg_b}, 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_a || busy_a) seen = 1'b1;
        end
        chk("drop_no_more_reads", {31'd0, seen}, 32'd0);
        $display("txn enable_drop: dial=%h delta=%h", dial_a, dlt_a);

        // Assert reset during CAPTURE. The transaction is discarded.
        src = 32'h0000_0099;
        enable = 1'b1;
        wait_read(20);
        @(posedge clk);                 // now in CAPTURE
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("midreset");
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (chg_a || chg_b || valid_a) seen = 1'b1;
        end
        chk("midreset_quiet", {31'd0, seen}, 32'd0);
        $display("txn reset_in_capture: dial=%h valid=%b", dial_a, valid_a);

        // After the reset, the first capture behaves as the first one ever.
        reset_n = 1'b1;
        src = 32'h0000_0007;
        wait_read(20);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_reset_dial", {16'd0, dial_a, dlt_a}, {16'd0, 8'h07, 8'h00});
        chk("post_reset_flags", {30'd0, valid_a, chg_a}, 32'd2);
        $display("txn post_reset: dial=%h delta=%h", dial_a, dlt_a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
